// File: rtl/rf_pkg.sv
// Shared definitions for the write-back register file and its scoreboard.
//   DATA_W / ADDR_W / NREG : register width, address width, register count
//   wdata_sel_e            : write-back data source select encoding
//   PEND_W / PEND_MAX      : width and ceiling of each pending-write counter
package rf_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NREG     = 2 ** ADDR_W;
  localparam int PEND_W   = 2;
  localparam int PEND_MAX = 3;

  typedef enum logic {
    WSEL_SRC = 1'b0,
    WSEL_MEM = 1'b1
  } wdata_sel_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters for RAW hazard detection.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   issue_ok, issue_addr  : accepted issue from decode (increments)
//   wb_hit, wb_addr       : write-back retiring a write (decrements)
//   addr_a, addr_b        : queried read addresses
//   addr_c                : queried issue destination
//   busy_a/b              : pend[addr] != 0
//   last_a/b              : pend[addr] == 1 (next retire frees it)
//   full_c                : pend[addr_c] == PEND_MAX
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_ok,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wb_hit,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_c,
  output logic              busy_a,
  output logic              busy_b,
  output logic              last_a,
  output logic              last_b,
  output logic              full_c
);
  logic [NREG-1:0][PEND_W-1:0] pend;
  logic [NREG-1:0]             inc, dec;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < NREG; r++) begin
      inc[r] = issue_ok && (issue_addr == ADDR_W'(r));
      dec[r] = wb_hit   && (wb_addr    == ADDR_W'(r));
    end
  end

  // R0 is never pending: only reset touches pend[0].
  // Issue and retire on the same register cancel; a retire at zero is an
  // unscoreboarded write and leaves the count at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (inc[r] && !dec[r])
          pend[r] <= pend[r] + 1'b1;
        else if (dec[r] && !inc[r] && pend[r] != '0)
          pend[r] <= pend[r] - 1'b1;
      end
    end
  end

  assign busy_a = pend[addr_a] != '0;
  assign busy_b = pend[addr_b] != '0;
  assign last_a = pend[addr_a] == PEND_W'(1);
  assign last_b = pend[addr_b] == PEND_W'(1);
  assign full_c = pend[addr_c] == PEND_W'(PEND_MAX);
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file: 16 x 16-bit array, two combinational read
// ports, and a pending-write scoreboard that stalls decode on RAW hazards.
// Optional macro WB_BYPASS_EN: forward the write-back data to same-cycle
// reads and let the retiring write-back release the stall a cycle earlier.
// Ports:
//   clk, rst_n                        : clock, async active-low reset
//   wb_wen, wb_waddr, wb_src_data,
//   wb_mem_data, wb_wdata_sel         : MEM/WB write-back controls and data
//   rd_addr_a/b, rd_use_a/b           : decode source addresses and use flags
//   rd_data_a/b                       : read data
//   id_issue, id_waddr                : decode issuing a register write
//   id_stall                          : hold decode this cycle
module wb_regfile
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_wen,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_src_data,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic              wb_wdata_sel,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              rd_use_a,
  input  logic              rd_use_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              id_issue,
  input  logic [ADDR_W-1:0] id_waddr,
  output logic              id_stall
);
  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [DATA_W-1:0]           wdata;
  logic                        wb_hit, issue_ok;
  logic                        busy_a, busy_b, last_a, last_b, full_c;
  logic                        blk_a, blk_b, hazard_a, hazard_b;

  assign wdata    = (wdata_sel_e'(wb_wdata_sel) == WSEL_MEM) ? wb_mem_data : wb_src_data;
  assign wb_hit   = wb_wen && (wb_waddr != '0);
  assign issue_ok = id_issue && !id_stall && (id_waddr != '0);

  // regs[0] is only ever cleared, so address 0 reads zero without a mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int r = 1; r < NREG; r++)
        if (wb_hit && wb_waddr == ADDR_W'(r)) regs[r] <= wdata;
    end
  end

  rf_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_ok   (issue_ok),
    .issue_addr (id_waddr),
    .wb_hit     (wb_hit),
    .wb_addr    (wb_waddr),
    .addr_a     (rd_addr_a),
    .addr_b     (rd_addr_b),
    .addr_c     (id_waddr),
    .busy_a     (busy_a),
    .busy_b     (busy_b),
    .last_a     (last_a),
    .last_b     (last_b),
    .full_c     (full_c)
  );

`ifdef WB_BYPASS_EN
  // The write-back retiring the last pending write satisfies the read now.
  assign rd_data_a = (wb_hit && wb_waddr == rd_addr_a) ? wdata : regs[rd_addr_a];
  assign rd_data_b = (wb_hit && wb_waddr == rd_addr_b) ? wdata : regs[rd_addr_b];
  assign blk_a     = busy_a && !(last_a && wb_hit && wb_waddr == rd_addr_a);
  assign blk_b     = busy_b && !(last_b && wb_hit && wb_waddr == rd_addr_b);
`else
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  assign blk_a     = busy_a;
  assign blk_b     = busy_b;
`endif

  assign hazard_a = rd_use_a && (rd_addr_a != '0) && blk_a;
  assign hazard_b = rd_use_b && (rd_addr_b != '0) && blk_b;
  assign id_stall = hazard_a || hazard_b || (id_issue && full_c);
endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_wen, wb_wdata_sel, rd_use_a, rd_use_b, id_issue;
  logic [3:0]  wb_waddr, rd_addr_a, rd_addr_b, id_waddr;
  logic [15:0] wb_src_data, wb_mem_data;
  logic [15:0] rd_data_a, rd_data_b;
  logic        id_stall;

  int checks = 0;
  int failures = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .wb_src_data(wb_src_data), .wb_mem_data(wb_mem_data), .wb_wdata_sel(wb_wdata_sel),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_use_a(rd_use_a), .rd_use_b(rd_use_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .id_issue(id_issue), .id_waddr(id_waddr),
    .id_stall(id_stall)
  );

  always #5 clk = ~clk;

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic idle();
    wb_wen = 0; wb_waddr = 0; wb_src_data = 0; wb_mem_data = 0; wb_wdata_sel = 0;
    rd_use_a = 0; rd_use_b = 0; rd_addr_a = 0; rd_addr_b = 0;
    id_issue = 0; id_waddr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [3:0] a, input logic [15:0] src, input logic [15:0] mem,
                    input logic sel);
    wb_wen = 1; wb_waddr = a; wb_src_data = src; wb_mem_data = mem; wb_wdata_sel = sel;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #12;
    // reset: all reads zero, no stall
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i); rd_use_a = 1; rd_use_b = 1;
      push("rst_rd_a", 0); push("rst_rd_b", 0); push("rst_stall", 0);
      #1;
      pop_chk(32'(rd_data_a)); pop_chk(32'(rd_data_b)); pop_chk(32'(id_stall));
    end
    idle();
    @(negedge clk); rst_n = 1;
    step();

    // ALU write R3
    wb(4'd3, 16'h1234, 16'h5555, 1'b0);
    step(); idle();
    rd_addr_a = 3; push("r3_src", 32'h1234); #1; pop_chk(32'(rd_data_a));

    // load path R5
    wb(4'd5, 16'h0001, 16'hBEEF, 1'b1);
    step(); idle();
    rd_addr_b = 5; push("r5_mem", 32'hBEEF); #1; pop_chk(32'(rd_data_b));

    // R0 write discarded, never stalls
    wb(4'd0, 16'hFFFF, 16'hFFFF, 1'b0);
    rd_addr_a = 0; rd_use_a = 1;
    push("r0_same", 0); push("r0_same_stall", 0); #1;
    pop_chk(32'(rd_data_a)); pop_chk(32'(id_stall));
    step(); wb_wen = 0;
    id_issue = 1; id_waddr = 0;
    push("r0_after", 0); push("r0_after_stall", 0); #1;
    pop_chk(32'(rd_data_a)); pop_chk(32'(id_stall));
    step(); idle();
    rd_addr_a = 0; rd_use_a = 1; push("r0_no_pend", 0); #1; pop_chk(32'(id_stall));
    idle();

    // RAW on R7
    id_issue = 1; id_waddr = 7;
    push("r7_issue_stall", 0); #1; pop_chk(32'(id_stall));
    step(); idle();
    rd_addr_a = 7; rd_use_a = 1;
    push("r7_raw_ex", 1); #1; pop_chk(32'(id_stall));
    step();
    push("r7_raw_mem", 1); #1; pop_chk(32'(id_stall));
    step();
    wb(4'd7, 16'h7777, 16'h0000, 1'b0);
`ifdef WB_BYPASS_EN
    push("r7_wb_stall", 0); push("r7_wb_data", 32'h7777);
`else
    push("r7_wb_stall", 1); push("r7_wb_data", 0);
`endif
    #1; pop_chk(32'(id_stall)); pop_chk(32'(rd_data_a));
    step(); wb_wen = 0;
    push("r7_post_stall", 0); push("r7_post_data", 32'h7777);
    #1; pop_chk(32'(id_stall)); pop_chk(32'(rd_data_a));
    idle();

    // R2 fills to pend=3
    id_issue = 1; id_waddr = 2;
    for (int i = 0; i < 3; i++) begin
      push("r2_fill_stall", 0); #1; pop_chk(32'(id_stall));
      step();
    end
    push("r2_full_stall", 1); #1; pop_chk(32'(id_stall));
    step();                                   // ignored issue
    wb(4'd2, 16'h2222, 16'h0000, 1'b0);
    push("r2_full_wb_stall", 1); #1; pop_chk(32'(id_stall));
    step(); wb_wen = 0;                       // pend 3 -> 2
    push("r2_after_wb", 0); #1; pop_chk(32'(id_stall));
    id_issue = 0;
    rd_addr_b = 2; rd_use_b = 1;
    push("r2_raw_p2", 1); #1; pop_chk(32'(id_stall));
    wb(4'd2, 16'h2223, 16'h0000, 1'b0);
    step();                                   // pend 1
    push("r2_raw_p1_wb", `ifdef WB_BYPASS_EN 0 `else 1 `endif); #1; pop_chk(32'(id_stall));
    step(); wb_wen = 0;                       // pend 0
    push("r2_clear", 0); push("r2_data", 32'h2223);
    #1; pop_chk(32'(id_stall)); pop_chk(32'(rd_data_b));
    idle();

    // R4: simultaneous issue and write-back with pend=1
    id_issue = 1; id_waddr = 4;
    step();                                   // pend 1
    wb(4'd4, 16'h4444, 16'h0000, 1'b0);
    push("r4_sim_stall", 0); #1; pop_chk(32'(id_stall));
    step(); idle();                           // pend stays 1
    rd_addr_a = 4; rd_use_a = 1;
    push("r4_still_pend", 1); push("r4_sim_data", 32'h4444);
    #1; pop_chk(32'(id_stall)); pop_chk(32'(rd_data_a));
    wb(4'd4, 16'h4445, 16'h0000, 1'b0);
    step(); wb_wen = 0;                       // pend 0
    push("r4_clear", 0); push("r4_data1", 32'h4445);
    #1; pop_chk(32'(id_stall)); pop_chk(32'(rd_data_a));
    wb(4'd4, 16'h0000, 16'h4446, 1'b1);
    step(); wb_wen = 0;                       // unscoreboarded write, pend saturates at 0
    push("r4_sat_stall", 0); push("r4_sat_data", 32'h4446);
    #1; pop_chk(32'(id_stall)); pop_chk(32'(rd_data_a));
    rd_use_a = 0; id_issue = 1; id_waddr = 4;
    step(); id_issue = 0; rd_use_a = 1;       // pend 1
    push("r4_reissue", 1); #1; pop_chk(32'(id_stall));
    rd_use_a = 0; wb(4'd4, 16'h4447, 16'h0000, 1'b0);
    step(); wb_wen = 0; rd_use_a = 1;         // pend 0 only if it did not wrap
    push("r4_no_wrap", 0); #1; pop_chk(32'(id_stall));
    idle();

    // reset mid-operation
    wb(4'd9, 16'h00AA, 16'h0000, 1'b0);
    step(); wb_wen = 0;
    id_issue = 1; id_waddr = 9;
    step(); step(); id_issue = 0;             // pend 2
    rd_addr_a = 9; rd_use_a = 1;
    push("r9_pre_stall", 1); push("r9_pre_data", 32'h00AA);
    #1; pop_chk(32'(id_stall)); pop_chk(32'(rd_data_a));
    #1 rst_n = 0;
    push("r9_rst_stall", 0); push("r9_rst_data", 0);
    #1; pop_chk(32'(id_stall)); pop_chk(32'(rd_data_a));
    @(negedge clk); rst_n = 1;
    step();
    push("r9_post_stall", 0); push("r9_post_data", 0);
    #1; pop_chk(32'(id_stall)); pop_chk(32'(rd_data_a));

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
